// File: rtl/arm_memsys.sv
// arm_memsys: memory-side responder for the multicycle ARM core bus.
//
// Word-addressed RAM with combinational read and full-word writes, plus a
// memory-mapped I/O page at Adr[31:16] == 16'hFFFF containing:
//   0x00 TXDATA  write pushes WriteData[7:0] into the console FIFO, reads 0
//   0x04 STATUS  {24'b0, count[3:0], 1'b0, overflow, empty, full}; any write
//                clears overflow
//   0x08 CYCLE   free-running cycle counter; any write loads 0
//
// Optional feature macro: ARM_MEMSYS_CYCLE_EN
//   defined   -> cycle counter is built
//   undefined -> no counter logic, CYCLE reads 0 and writes are ignored
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   MemWrite   write strobe qualifying Adr/WriteData
//   Adr        byte address
//   WriteData  write data
//   ReadData   combinational read data for the current Adr
//   tx_data    FIFO head byte (0 when empty)
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head when tx_valid && tx_ready
module arm_memsys #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Storage
  logic [31:0]   mem_q  [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  // FIFO control state
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Decode / control
  logic          io_sel_s;
  logic          ram_wr_s;
  logic          io_wr_s;
  logic          push_req_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          ovf_set_s;
  logic          status_wr_s;
  logic [AW-1:0] ram_idx_s;
  logic [3:0]    count4_s;
  logic [31:0]   status_s;
  logic [31:0]   cycle_rd_s;
  logic [31:0]   io_rd_s;
  logic          unused_adr_s;

  // Address bits outside the RAM index and I/O offset are intentionally ignored.
  assign unused_adr_s = ^Adr;

  assign io_sel_s    = (Adr[31:16] == 16'hFFFF);
  assign ram_wr_s    = MemWrite && !io_sel_s;
  assign io_wr_s     = MemWrite && io_sel_s;
  assign ram_idx_s   = Adr[AW+1:2];
  assign push_req_s  = io_wr_s && (Adr[7:0] == 8'h00);
  assign status_wr_s = io_wr_s && (Adr[7:0] == 8'h04);

  assign empty_s  = (count_q == CW'(0));
  assign full_s   = (count_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty_s;
  assign tx_data  = empty_s ? 8'h00 : fifo_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a push into a full FIFO with a
  // concurrent pop is accepted rather than dropped.
  assign pop_s     = tx_valid && tx_ready;
  assign push_s    = push_req_s && (!full_s || pop_s);
  assign ovf_set_s = push_req_s && full_s && !pop_s;

  assign count4_s = 4'(count_q);
  assign status_s = {24'h000000, count4_s, 1'b0, ovf_q, empty_s, full_s};

`ifdef ARM_MEMSYS_CYCLE_EN
  logic [31:0] cycle_q, cycle_d;
  logic        cycle_wr_s;

  assign cycle_wr_s = io_wr_s && (Adr[7:0] == 8'h08);
  assign cycle_rd_s = cycle_q;

  // Counter next state: a CYCLE write wins over the increment.
  always_comb begin
    cycle_d = cycle_q;
    if (cycle_wr_s) begin
      cycle_d = 32'h00000000;
    end else begin
      cycle_d = cycle_q + 32'h00000001;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q <= 32'h00000000;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`else
  assign cycle_rd_s = 32'h00000000;
`endif

  // FIFO pointer, count and overflow next state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    if (status_wr_s) begin
      ovf_d = 1'b0;
    end else if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO control registers; reset discards contents and any push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO data storage; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      fifo_q[wr_ptr_q] <= WriteData[7:0];
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  // RAM write port; RAM is not touched by reset and still writes during it.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      mem_q[ram_idx_s] <= WriteData;
    end else begin
      mem_q[ram_idx_s] <= mem_q[ram_idx_s];
    end
  end

  // Combinational read mux for RAM and the I/O page.
  always_comb begin
    io_rd_s = 32'h00000000;
    case (Adr[7:0])
      8'h04:   io_rd_s = status_s;
      8'h08:   io_rd_s = cycle_rd_s;
      default: io_rd_s = 32'h00000000;
    endcase
    if (io_sel_s) begin
      ReadData = io_rd_s;
    end else begin
      ReadData = mem_q[ram_idx_s];
    end
  end

endmodule

// File: doc/arm_memsys.md
# arm_memsys

Memory-side responder for the multicycle ARM core's unified memory bus (MemWrite, Adr, WriteData, ReadData). It provides word-addressed instruction/data RAM, plus a small memory-mapped I/O page. The I/O page holds a byte-wide console transmit FIFO, drained over a valid/ready stream, and a free-running cycle counter. It sits beside the core at the top level, taking the core's bus outputs and returning ReadData in the same cycle.

## Interface
- MEM_WORDS, 64: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: console FIFO entries; power of two, ≥2.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- MemWrite  input  1  write strobe from core, qualifies Adr/WriteData for one cycle.
- Adr  input  32  byte address from core.
- WriteData  input  32  write data from core.
- ReadData  output  32  combinational read data for current Adr.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts head when tx_valid && tx_ready at rising edge.

## Operation
- Decode: Adr[31:16]==16'hFFFF selects the I/O page; any other address selects RAM.
- RAM: index Adr[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so addresses alias. Adr[1:0] is ignored; byte extraction (LDRB) is done in the core.
- RAM write: MemWrite=1 writes the full word at the rising edge. RAM contents are not affected by reset.
- RAM read: ReadData = mem[index], combinational, with no wait states. A read in the cycle after a write returns the new data.
- I/O page registers (Adr[7:0]; other offsets read 0 and ignore writes):
  - 0x00 TXDATA: a write pushes WriteData[7:0]. Reads return 0.
  - 0x04 STATUS: reads return {24'b0, count[3:0], overflow, empty, full} in bits [7:4], [2], [1], [0]. Bit 3 reads 0. Any write clears overflow.
  - 0x08 CYCLE: reads return the 32-bit counter. Any write loads 0.
- FIFO behaviour:
  - Circular buffer with read/write pointers and a count.
  - Pop: tx_valid && tx_ready.
  - Push: a TXDATA write.
  - Push when full with no pop in the same cycle: the byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: both are performed; count is unchanged and overflow is not set.
  - Push and pop in the same cycle while non-empty: count is unchanged.
  - Pop when empty: impossible, because tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_data shows the head entry. It is stable while tx_valid && !tx_ready.
- Cycle counter: increments by 1 every cycle it is not being cleared, and wraps 32'hFFFFFFFF→0. A CYCLE write takes priority over the increment.

## Timing
- Reset (reset=0 at an edge) sets:
  - FIFO empty, pointers 0, overflow 0, counter 0.
  - tx_valid=0; tx_data is don't-care and driven 0.
  - ReadData still reflects RAM/I/O combinationally.
- Reset mid-operation discards FIFO contents and any push or pop in that cycle. RAM writes in that cycle are still performed.
- Write latency: one edge. Register effects are visible to reads in the next cycle.
- tx_valid rises in the cycle after the first push into an empty FIFO, and falls in the cycle after the last pop.
- STATUS read in the same cycle as a push or pop returns the pre-edge value.
- Throughput: one push and one pop per cycle.

## Configuration
- ARM_MEMSYS_CYCLE_EN:
  - Defined: the cycle counter exists as specified.
  - Undefined: there is no counter logic; CYCLE reads return 0 and writes are ignored.
- All other behaviour is identical in both builds.

## Test plan
- RAM write/read: write 32'hDEADBEEF at Adr 0x20, then read 0x20 → 32'hDEADBEEF. Read 0x20+4·MEM_WORDS → the same value (alias).
- FIFO order: tx_ready=0; write 0x41, 0x42, 0x43 to 0xFFFF0000; STATUS → 0x30 (count 3). Raise tx_ready → tx_data 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and STATUS=0x02.
- Overflow: tx_ready=0; push 5 bytes with FIFO_DEPTH=4 → STATUS=0x45 (count 4, overflow, full). Fifth byte lost. STATUS write → overflow clears, STATUS=0x41.
- Full push+pop: FIFO full with tx_ready=1 and a push in the same cycle → count stays 4, overflow stays 0, new byte emerges last.
- Cycle counter (macro defined): write CYCLE, wait 10 cycles, read → 10. Force counter to 32'hFFFFFFFF → next read 0. Macro undefined → reads 0.
- Reset mid-stream: 3 bytes queued, reset=0 for one edge → tx_valid=0, STATUS=0x02, counter 0. RAM word at 0x20 is still 32'hDEADBEEF.
